// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential restoring divider, 14-bit dividend by 7-bit
//                divisor, one shift-subtract per clock. Produces a 7-bit
//                quotient and remainder with start/busy/done handshake.
//                Optional MSB-first serial quotient stream (q_bit/q_valid)
//                is enabled by defining SEQ_DIVIDER_SERIAL_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] dividend,
    input  logic [6:0]  divisor,
    output logic [6:0]  quotient,
    output logic [6:0]  remainder,
    output logic        busy,
    output logic        done,
`ifdef SEQ_DIVIDER_SERIAL_EN
    output logic        q_bit,
    output logic        q_valid,
`endif
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [6:0]  r_rem;        // partial remainder, invariant r_rem < r_divisor
    logic [6:0]  r_dvd_lo;     // low dividend bits, consumed MSB first
    logic [6:0]  r_divisor;
    logic [5:0]  r_q;          // quotient bits gathered so far
    logic [2:0]  r_cnt;        // iterations completed in RUN
    logic [6:0]  r_quotient;
    logic [6:0]  r_remainder;
    logic        r_ovf;

    logic        w_accept;
    logic        w_bad;
    logic        w_last;
    logic [7:0]  w_trial;
    logic        w_ge;
    logic        w_qbit;
    logic [6:0]  w_rem_next;

    // Trial subtraction: bring down the next dividend bit and compare.
    // When T >= divisor the difference is below divisor (< 128), so the low
    // 7 bits of a modulo-128 subtraction are exact.
    assign w_trial    = {r_rem, r_dvd_lo[6]};
    assign w_ge       = (w_trial >= {1'b0, r_divisor});
    assign w_qbit     = w_ge;
    assign w_rem_next = w_ge ? (w_trial[6:0] - r_divisor) : w_trial[6:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and accept/overflow decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_bad        = (divisor == 7'd0) || (dividend[13:7] >= divisor);
        w_last       = (r_cnt == 3'd6);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one restoring step per RUN cycle, result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= 7'd0;
            r_dvd_lo    <= 7'd0;
            r_divisor   <= 7'd0;
            r_q         <= 6'd0;
            r_cnt       <= 3'd0;
            r_quotient  <= 7'd0;
            r_remainder <= 7'd0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= dividend[13:7];
            r_dvd_lo  <= dividend[6:0];
            r_divisor <= divisor;
            r_q       <= 6'd0;
            r_cnt     <= 3'd0;
            r_ovf     <= w_bad;
            if (w_bad) begin
                r_quotient  <= 7'h7F;
                r_remainder <= 7'd0;
            end
        end else if (r_state == S_RUN) begin
            r_rem    <= w_rem_next;
            r_dvd_lo <= {r_dvd_lo[5:0], 1'b0};
            r_q      <= {r_q[4:0], w_qbit};
            r_cnt    <= r_cnt + 3'd1;
            if (w_last) begin
                r_quotient  <= {r_q, w_qbit};
                r_remainder <= w_rem_next;
            end
        end
    end

`ifdef SEQ_DIVIDER_SERIAL_EN
    logic r_q_bit;
    logic r_q_valid;

    // Serial stream: each freshly computed quotient bit, MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_bit   <= 1'b0;
            r_q_valid <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_q_bit   <= w_qbit;
            r_q_valid <= 1'b1;
        end else begin
            r_q_valid <= 1'b0;
        end
    end

    assign q_bit   = r_q_bit;
    assign q_valid = r_q_valid;
`endif

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider: directed cases plus
//                randomized divisions against an arithmetic reference model.
//                Serial stream checks follow SEQ_DIVIDER_SERIAL_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] dividend;
    logic [6:0]  divisor;
    logic [6:0]  quotient;
    logic [6:0]  remainder;
    logic        busy;
    logic        done;
    logic        ovf;
`ifdef SEQ_DIVIDER_SERIAL_EN
    logic        q_bit;
    logic        q_valid;
`endif

    int n_checks;
    int n_errors;

    seq_divider u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
`ifdef SEQ_DIVIDER_SERIAL_EN
        .q_bit     (q_bit),
        .q_valid   (q_valid),
`endif
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one division, follow it to done and compare against plain arithmetic.
    task automatic run_div(input logic [13:0] dvd, input logic [6:0] dvs);
        int         exp_q;
        int         exp_r;
        int         exp_o;
        int         lat;
        int         busy_lo;
        int         nbits;
        logic [6:0] sbits;
        logic       seen;
        logic       last_valid;

        if (dvs == 7'd0 || (int'(dvd) / int'(dvs)) > 127) begin
            exp_o = 1; exp_q = 127; exp_r = 0;
        end else begin
            exp_o = 0;
            exp_q = int'(dvd) / int'(dvs);
            exp_r = int'(dvd) % int'(dvs);
        end

        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 14'($urandom);
        divisor  = 7'($urandom);

        lat = 1; busy_lo = 0; nbits = 0; sbits = 7'd0; seen = 1'b0; last_valid = 1'b0;
        while (!seen && lat <= 20) begin
            if (!busy) busy_lo++;
`ifdef SEQ_DIVIDER_SERIAL_EN
            last_valid = q_valid;
            if (q_valid) begin
                sbits = {sbits[5:0], q_bit};
                nbits++;
            end
`endif
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end

        chk("done_seen", 32'(seen), 32'd1);
        chk("latency",   32'(lat), (exp_o != 0) ? 32'd1 : 32'd8);
        chk("busy_thru", 32'(busy_lo), 32'd0);
        chk("quotient",  32'(quotient), 32'(exp_q));
        chk("remainder", 32'(remainder), 32'(exp_r));
        chk("ovf",       32'(ovf), 32'(exp_o));
`ifdef SEQ_DIVIDER_SERIAL_EN
        chk("q_count",   32'(nbits), (exp_o != 0) ? 32'd0 : 32'd7);
        chk("q_last",    32'(last_valid), (exp_o != 0) ? 32'd0 : 32'd1);
        if (exp_o == 0) chk("q_stream", 32'(sbits), 32'(exp_q));
`else
        chk("q_none", 32'(nbits + int'(last_valid)), 32'd0);
`endif

        @(posedge clk);
        #1;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("hold_q",     32'(quotient), 32'(exp_q));
`ifdef SEQ_DIVIDER_SERIAL_EN
        chk("qv_after",   32'(q_valid), 32'd0);
`endif
    endtask

    // Directed and randomized sequence.
    initial begin
        int         lat;
        logic [6:0] dvs;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 14'd0;
        divisor  = 7'd0;
        #1;
        chk("rst_q",    32'(quotient), 32'd0);
        chk("rst_r",    32'(remainder), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf",  32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(14'd100,   7'd7);
        run_div(14'd16255, 7'd127);
        run_div(14'd3000,  7'd0);
        run_div(14'd100,   7'd7);
        run_div(14'd1000,  7'd5);
        run_div(14'd0,     7'd1);
        run_div(14'd127,   7'd1);

        // Mid-run start with new operands must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 14'd100; divisor = 7'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 14'd200; divisor = 7'd3;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_q",    32'(quotient), 32'd14);
        chk("ign_r",    32'(remainder), 32'd2);
        @(posedge clk);
        #1;
        chk("ign_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_restart", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_q",    32'(quotient), 32'd0);
        chk("mrst_r",    32'(remainder), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_ovf",  32'(ovf), 32'd0);
`ifdef SEQ_DIVIDER_SERIAL_EN
        chk("mrst_qv",   32'(q_valid), 32'd0);
        chk("mrst_qb",   32'(q_bit), 32'd0);
`endif
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_div(14'd50, 7'd6);

        // Random mix: mostly in-range quotients, some arbitrary operands.
        for (int i = 0; i < 40; i++) begin
            dvs = 7'($urandom_range(1, 127));
            if (i % 4 == 3) begin
                run_div(14'($urandom), 7'($urandom));
            end else begin
                run_div(14'($urandom_range(0, int'(dvs) * 128 - 1)), dvs);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
